inst_queue: RTL
===============

# inst_queue

Decoupling FIFO between the fetch frontend and the decode/rename stage. It buffers whole fetch packets of up to ID_WIDTH sequential instructions, together with their per-slot branch-prediction tags. It presents the oldest packet to decode through a valid/ready handshake. A backend flush discards all buffered packets after a misprediction.

## Interface
Parameters:
- DEPTH, 8: number of packet entries; power of two, at least 2.
- ID_WIDTH, from cpu_params: instruction slots per packet.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  frontend offers a packet.
- in_ready  out  1  queue can accept a packet this cycle.
- in_pc  in  32  PC of slot 0.
- in_inst_valid  in  ID_WIDTH  per-slot valid bits.
- in_inst  in  ID_WIDTH x 32  per-slot instruction words.
- in_predict_taken  in  ID_WIDTH  per-slot predicted-taken bits.
- in_predict_target  in  ID_WIDTH x 32  per-slot predicted targets.
- out_valid  out  1  head packet is available (the backend-side valid).
- out_ready  in  1  decode consumes the head packet this cycle.
- out_pc, out_inst_valid, out_inst, out_predict_taken, out_predict_target  out  same widths as the inputs  head-packet fields.
- flush  in  1  synchronous discard of all contents.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Storage is a circular buffer of DEPTH entries with head and tail pointers. Each pointer is $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- Empty condition: head == tail.
- Full condition: indices equal and wrap bits differ.
- Combinational outputs:
  - in_ready = !full.
  - out_valid = !empty.
  - count = tail - head, modulo 2^($clog2(DEPTH)+1).
- Push: in_valid && in_ready. The packet is written at tail[idx] and tail increments. Packets whose in_inst_valid is all zero are stored like any other packet.
- Pop: out_valid && out_ready. head increments.
- out_* fields are driven from the entry at head[idx]. They are don't-care while out_valid = 0.
- Simultaneous push and pop when neither full nor empty: both happen and count is unchanged.
- Push while full: in_ready = 0, so no write occurs, even if a pop happens in the same cycle. There is no full-bypass, which keeps in_ready free of any combinational path from out_ready.
- Pop while empty: out_valid = 0, so nothing happens. There is no empty-bypass: a pushed packet is visible on out_* at the earliest in the cycle after the push.
- flush = 1: on the next edge head and tail are set to 0, and any push or pop in the same cycle is ignored. flush has priority over both.
- Data entries are not reset and not cleared on flush; only the pointers are.
- Pointer wrap: idx rolls from DEPTH-1 to 0 and the wrap bit toggles.

## Timing
- Reset (asynchronous assert, synchronous-edge release): head = tail = 0.
  - Giving: in_ready = 1, out_valid = 0, count = 0.
  - out_* data fields are undefined after reset.
- Push-to-visible latency: 1 cycle. A packet accepted at edge N drives out_valid = 1 after edge N if the queue was empty.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- At count == DEPTH, in_ready deasserts in the cycle following the filling push. It reasserts in the cycle after the first pop.
- Handshake rules:
  - Frontend holds in_* stable while in_valid && !in_ready.
  - Queue holds out_* stable while out_valid && !out_ready; the head does not move without a pop.
- Flush: asserting flush at edge N yields out_valid = 0, in_ready = 1 and count = 0 after edge N. A push in cycle N+1 is accepted normally.
- Reset mid-operation: all in-flight contents are lost immediately on rst assertion, with no dependence on clk.

## Test plan
- Fill and drain (DEPTH = 8, out_ready = 0): push 8 packets with PC 0x1000, 0x1008, … → count = 8 and in_ready = 0 after the 8th push, and a 9th in_valid is not accepted. Then set out_ready = 1 → packets pop in PC order 0x1000…0x1038, one per cycle, and out_valid = 0 after the 8th pop.
- Simultaneous push and pop at full: with count = 8, assert in_valid and out_ready together → head advances, no write, count = 7; in_ready = 1 in the next cycle.
- Wrap-around: hold a steady state of count = 3 with a push and a pop every cycle for 20 cycles → the output PC sequence equals the input sequence with no gaps or duplicates, and count stays 3 throughout.
- Flush priority: with count = 5, assert flush, in_valid and out_ready in the same cycle → the next cycle shows count = 0 and out_valid = 0. A subsequent push with PC 0x2000 appears on out_pc one cycle later.
- Slot fields: push in_inst_valid = 2'b01, in_predict_taken = 2'b10, in_predict_target[1] = 0x3000 → the popped packet reproduces exactly those values. Also push an all-zero in_inst_valid packet → it is stored and popped like any other.
- Asynchronous reset: assert rst mid-cycle with count = 4 → out_valid = 0, count = 0 and in_ready = 1 before the next clk edge.

Source files
------------

// File: rtl/inst_queue.sv
// Fetch-to-decode packet FIFO: circular buffer with wrap-bit pointers,
// valid/ready handshakes on both sides and a synchronous flush.
module inst_queue #(
    parameter int DEPTH    = 8,
    parameter int ID_WIDTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [31:0]                       in_pc,
    input  logic [ID_WIDTH-1:0]               in_inst_valid,
    input  logic [ID_WIDTH-1:0][31:0]         in_inst,
    input  logic [ID_WIDTH-1:0]               in_predict_taken,
    input  logic [ID_WIDTH-1:0][31:0]         in_predict_target,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [31:0]                       out_pc,
    output logic [ID_WIDTH-1:0]               out_inst_valid,
    output logic [ID_WIDTH-1:0][31:0]         out_inst,
    output logic [ID_WIDTH-1:0]               out_predict_taken,
    output logic [ID_WIDTH-1:0][31:0]         out_predict_target,
    input  logic                              flush,
    output logic [$clog2(DEPTH):0]            count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [31:0]               pc;
        logic [ID_WIDTH-1:0]       inst_valid;
        logic [ID_WIDTH-1:0][31:0] inst;
        logic [ID_WIDTH-1:0]       taken;
        logic [ID_WIDTH-1:0][31:0] target;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        head_e;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic          full, empty, push, pop;

    assign empty = (head_q == tail_q);
    assign full  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = tail_q - head_q;

    // Flush overrides both sides; no bypass paths between in_* and out_*.
    assign push = in_valid && !full && !flush;
    assign pop  = out_ready && !empty && !flush;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (pop)  head_d = head_q + PW'(1);
            if (push) tail_d = tail_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Payload storage is intentionally unreset; only pointers carry state.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q[AW-1:0]] <= '{pc: in_pc, inst_valid: in_inst_valid,
                                       inst: in_inst, taken: in_predict_taken,
                                       target: in_predict_target};
        end
    end

    assign head_e             = mem_q[head_q[AW-1:0]];
    assign out_pc             = head_e.pc;
    assign out_inst_valid     = head_e.inst_valid;
    assign out_inst           = head_e.inst;
    assign out_predict_taken  = head_e.taken;
    assign out_predict_target = head_e.target;

endmodule
